text_console: RTL and testbench

//  Parametrised successor to the fixed keyboard-to-screen text path. Accepts an ASCII

---
 rtl/text_console_pkg.sv | 35 +++
 rtl/text_console_if.sv | 25 ++
 rtl/text_ram.sv | 24 ++
 rtl/text_console.sv | 225 ++++++++++++++++++++++
 tb/tb_text_console.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console: FSM states, ASCII codes
// and the width helper used to size cursor, row and cell counters.
package text_console_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_TILDE = 8'h7E;

    // Bits needed to index n items; never less than one.
    function automatic int clog2w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cols_w(input int cols);
        return clog2w(cols);
    endfunction

    function automatic int rows_w(input int rows);
        return clog2w(rows);
    endfunction

    function automatic int cells_w(input int cols, input int rows);
        return clog2w(cols * rows);
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte-stream input and VGA read-side signals of the text console.
// The keyboard/VGA side uses master, the console uses slave.
interface text_console_if;

    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    logic [7:0] ascii_out;
    logic [3:0] row;
    logic [3:0] col;
    logic       cursor_on;

    modport master (
        output in_valid, in_char, h_addr, v_addr,
        input  in_ready, ascii_out, row, col, cursor_on
    );

    modport slave (
        input  in_valid, in_char, h_addr, v_addr,
        output in_ready, ascii_out, row, col, cursor_on
    );

endinterface

// File: rtl/text_ram.sv
// Character buffer: one write port, one registered read-first read port.
// A write and a read of the same cell in one cycle returns the old byte.
module text_ram #(
    parameter int DEPTH = 2100,
    parameter int AW    = 12
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rd_data_p1
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_data_p1 <= mem[raddr];
    end

endmodule

// File: rtl/text_console.sv
// Character console: ASCII stream in, COLS x ROWS buffer with cursor, wrap,
// backspace and hardware scroll; serves char/glyph position/cursor to VGA.
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int FONT_W       = 9,
    parameter int FONT_H       = 16,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic      clock,
    input  logic      reset,
    text_console_if.slave tc
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = cells_w(COLS, ROWS);
    localparam int XW    = cols_w(COLS);
    localparam int YW    = rows_w(ROWS);
    localparam int BW    = clog2w(BLINK_CYCLES);

    localparam logic [XW-1:0] X_LAST     = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(ROWS - 1);
    localparam logic [AW-1:0] CELL_LAST  = AW'(CELLS - 1);
    localparam logic [AW-1:0] SCRL_LAST  = AW'(COLS - 1);
    localparam logic [YW:0]   ROWS_E     = (YW + 1)'(ROWS);
    localparam logic [9:0]    COLS10     = 10'(COLS);
    localparam logic [9:0]    ROWS10     = 10'(ROWS);
    localparam logic [9:0]    FW10       = 10'(FONT_W);
    localparam logic [9:0]    FH10       = 10'(FONT_H);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // Logical line -> physical row, wrapping at ROWS without a modulo.
    function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] base,
                                               input logic [YW-1:0] y);
        logic [YW:0] sum;
        sum = {1'b0, base} + {1'b0, y};
        if (sum >= ROWS_E) begin
            sum = sum - ROWS_E;
        end
        return sum[YW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] prow,
                                                input logic [XW-1:0] x);
        return AW'(int'(prow) * COLS + int'(x));
    endfunction

    state_t        state, state_nx;
    logic [AW-1:0] clr_cnt, clr_cnt_nx;
    logic [XW-1:0] cur_x, cur_x_nx;
    logic [YW-1:0] cur_y, cur_y_nx;
    logic [YW-1:0] top, top_nx;
    logic [YW-1:0] scroll_row, scroll_row_nx;
    logic          do_nl;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [9:0]    cx, cy;
    logic          in_range;
    logic [AW-1:0] raddr;
    logic          cursor_hit;
    logic [3:0]    glyph_row, glyph_col;

    logic [7:0]    rd_data_p1;
    logic          rd_ok_p1;
    logic [3:0]    glyph_row_p1, glyph_col_p1;
    logic          cursor_p1;

    assign tc.in_ready = (state == ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            top        <= '0;
            scroll_row <= '0;
        end else begin
            state      <= state_nx;
            clr_cnt    <= clr_cnt_nx;
            cur_x      <= cur_x_nx;
            cur_y      <= cur_y_nx;
            top        <= top_nx;
            scroll_row <= scroll_row_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        clr_cnt_nx    = clr_cnt;
        cur_x_nx      = cur_x;
        cur_y_nx      = cur_y;
        top_nx        = top;
        scroll_row_nx = scroll_row;
        do_nl         = 1'b0;
        we            = 1'b0;
        waddr         = cell_addr(phys_row(top, cur_y), cur_x);
        wdata         = ASC_SPACE;

        case (state)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = clr_cnt;
                if (clr_cnt == CELL_LAST) begin
                    clr_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end else begin
                    clr_cnt_nx = clr_cnt + AW'(1);
                end
            end
            ST_SCROLL: begin
                we    = 1'b1;
                waddr = cell_addr(scroll_row, clr_cnt[XW-1:0]);
                if (clr_cnt == SCRL_LAST) begin
                    clr_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end else begin
                    clr_cnt_nx = clr_cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                if (tc.in_valid) begin
                    if (tc.in_char >= ASC_SPACE && tc.in_char <= ASC_TILDE) begin
                        we    = 1'b1;
                        wdata = tc.in_char;
                        if (cur_x == X_LAST) begin
                            do_nl = 1'b1;
                        end else begin
                            cur_x_nx = cur_x + XW'(1);
                        end
                    end else if (tc.in_char == ASC_LF || tc.in_char == ASC_CR) begin
                        do_nl = 1'b1;
                    end else if (tc.in_char == ASC_BS) begin
                        if (cur_x != '0) begin
                            cur_x_nx = cur_x - XW'(1);
                            we       = 1'b1;
                            waddr    = cell_addr(phys_row(top, cur_y), cur_x - XW'(1));
                        end else if (cur_y != '0) begin
                            cur_x_nx = X_LAST;
                            cur_y_nx = cur_y - YW'(1);
                            we       = 1'b1;
                            waddr    = cell_addr(phys_row(top, cur_y - YW'(1)), X_LAST);
                        end
                    end
                end
            end
            default: begin
                state_nx = ST_CLEAR;
            end
        endcase

        // On the last line the old top row becomes the new bottom and is blanked.
        if (do_nl) begin
            cur_x_nx = '0;
            if (cur_y != Y_LAST) begin
                cur_y_nx = cur_y + YW'(1);
            end else begin
                top_nx        = (top == Y_LAST) ? '0 : top + YW'(1);
                scroll_row_nx = top;
                clr_cnt_nx    = '0;
                state_nx      = ST_SCROLL;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    assign cx         = tc.h_addr / FW10;
    assign cy         = tc.v_addr / FH10;
    assign glyph_col  = 4'(tc.h_addr % FW10);
    assign glyph_row  = 4'(tc.v_addr % FH10);
    assign in_range   = (cx < COLS10) && (cy < ROWS10);
    assign raddr      = in_range ? cell_addr(phys_row(top, cy[YW-1:0]), cx[XW-1:0]) : '0;
    assign cursor_hit = in_range && (cx == 10'(cur_x)) && (cy == 10'(cur_y)) && blink_phase;

    text_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clock      (clock),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rd_data_p1 (rd_data_p1)
    );

    // ---- stage p1: registered read-side outputs ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ok_p1     <= 1'b0;
            glyph_row_p1 <= '0;
            glyph_col_p1 <= '0;
            cursor_p1    <= 1'b0;
        end else begin
            rd_ok_p1     <= in_range;
            glyph_row_p1 <= glyph_row;
            glyph_col_p1 <= glyph_col;
            cursor_p1    <= cursor_hit;
        end
    end

    assign tc.ascii_out = rd_ok_p1 ? rd_data_p1 : ASC_NUL;
    assign tc.row       = glyph_row_p1;
    assign tc.col       = glyph_col_p1;
    assign tc.cursor_on = cursor_p1;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a 4x3 screen, 9x16 font, 8-cycle blink.
module tb_text_console;

    localparam int COLS   = 4;
    localparam int ROWS   = 3;
    localparam int FONT_W = 9;
    localparam int FONT_H = 16;
    localparam int BLINK  = 8;

    logic clock = 1'b0;
    logic reset;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    text_console_if tc();

    text_console #(
        .COLS(COLS), .ROWS(ROWS), .FONT_W(FONT_W), .FONT_H(FONT_H), .BLINK_CYCLES(BLINK)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tc    (tc)
    );

    always #5 clock = ~clock;

    task automatic wait_ready();
        int n;
        n = 0;
        while (tc.in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (tc.in_ready !== 1'b1) begin
            vec_cnt++; err_cnt++;
            $display("FAIL ready_timeout: in_ready=%b required 1", tc.in_ready);
        end
    endtask

    task automatic send_byte(input logic [7:0] c);
        @(negedge clock);
        wait_ready();
        tc.in_valid = 1'b1;
        tc.in_char  = c;
        @(posedge clock); #1;
        tc.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic read_pixel(input int h, input int v);
        @(negedge clock);
        tc.h_addr = 10'(h);
        tc.v_addr = 10'(v);
        @(posedge clock); #1;
    endtask

    task automatic cursor_hits(input int h, input int v, output int hits);
        hits = 0;
        @(negedge clock);
        tc.h_addr = 10'(h);
        tc.v_addr = 10'(v);
        repeat (16) begin
            @(posedge clock); #1;
            if (tc.cursor_on === 1'b1) hits++;
        end
    endtask

    task automatic release_reset(output int n);
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (tc.in_ready !== 1'b1 && n < 100);
    endtask

    task automatic hard_reset(output int n);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        release_reset(n);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        tc.h_addr = 10'd10;
        tc.v_addr = 10'd17;
        repeat (3) @(posedge clock); #1;
        vec_cnt++; if (tc.in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready: got %b want 0", tc.in_ready); end
        vec_cnt++; if (tc.ascii_out !== 8'h00) begin err_cnt++; $display("FAIL rst_ascii: got %h want 00", tc.ascii_out); end
        vec_cnt++; if (tc.row !== 4'd0) begin err_cnt++; $display("FAIL rst_row: got %0d want 0", tc.row); end
        vec_cnt++; if (tc.col !== 4'd0) begin err_cnt++; $display("FAIL rst_col: got %0d want 0", tc.col); end
        vec_cnt++; if (tc.cursor_on !== 1'b0) begin err_cnt++; $display("FAIL rst_cursor: got %b want 0", tc.cursor_on); end
        release_reset(n);
        vec_cnt++; if (n !== 12) begin err_cnt++; $display("FAIL clear_cycles: got %0d want 12", n); end
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                read_pixel(x * FONT_W, y * FONT_H);
                vec_cnt++;
                if (tc.ascii_out !== 8'h20) begin
                    err_cnt++; $display("FAIL clear_cell(%0d,%0d): got %h want 20", x, y, tc.ascii_out);
                end
            end
        end
    endtask

    task automatic test_chars();
        int hits, n, same;
        logic prev;
        send_str("AB");
        read_pixel(0, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h41) begin err_cnt++; $display("FAIL char_A: got %h want 41", tc.ascii_out); end
        read_pixel(9, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h42) begin err_cnt++; $display("FAIL char_B: got %h want 42", tc.ascii_out); end
        read_pixel(10, 17);
        vec_cnt++; if (tc.col !== 4'd1) begin err_cnt++; $display("FAIL glyph_col: got %0d want 1", tc.col); end
        vec_cnt++; if (tc.row !== 4'd1) begin err_cnt++; $display("FAIL glyph_row: got %0d want 1", tc.row); end
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL cell_1_1: got %h want 20", tc.ascii_out); end
        cursor_hits(0, 0, hits);
        vec_cnt++; if (hits !== 0) begin err_cnt++; $display("FAIL cursor_off_0_0: got %0d want 0", hits); end
        @(negedge clock);
        tc.h_addr = 10'd18;
        tc.v_addr = 10'd0;
        @(posedge clock); #1;
        prev = tc.cursor_on;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (tc.cursor_on === prev && n < 20);
        vec_cnt++; if (tc.cursor_on === prev) begin err_cnt++; $display("FAIL blink_edge: cursor_on stuck at %b, want a toggle", prev); end
        prev = tc.cursor_on;
        same = 0;
        repeat (7) begin
            @(posedge clock); #1;
            if (tc.cursor_on === prev) same++;
        end
        vec_cnt++; if (same !== 7) begin err_cnt++; $display("FAIL blink_hold: got %0d steady cycles want 7", same); end
        @(posedge clock); #1;
        vec_cnt++; if (tc.cursor_on !== ~prev) begin err_cnt++; $display("FAIL blink_flip: got %b want %b", tc.cursor_on, ~prev); end
    endtask

    task automatic test_wrap_bs();
        int n, hits;
        hard_reset(n);
        vec_cnt++; if (n !== 12) begin err_cnt++; $display("FAIL wrap_clear_cycles: got %0d want 12", n); end
        send_byte(8'h08);
        cursor_hits(0, 0, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL bs_origin_cursor: got %0d want 8", hits); end
        cursor_hits(27, 32, hits);
        vec_cnt++; if (hits !== 0) begin err_cnt++; $display("FAIL bs_origin_stray: got %0d want 0", hits); end
        send_str("ABCDE");
        read_pixel(0, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h45) begin err_cnt++; $display("FAIL wrap_E: got %h want 45", tc.ascii_out); end
        read_pixel(27, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h44) begin err_cnt++; $display("FAIL wrap_D: got %h want 44", tc.ascii_out); end
        cursor_hits(9, 16, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL wrap_cursor: got %0d want 8", hits); end
        send_byte(8'h08);
        read_pixel(0, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL bs_erase_E: got %h want 20", tc.ascii_out); end
        cursor_hits(0, 16, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL bs_cursor_0_1: got %0d want 8", hits); end
        send_byte(8'h08);
        read_pixel(27, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL bs_erase_D: got %h want 20", tc.ascii_out); end
        cursor_hits(27, 0, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL bs_cursor_3_0: got %0d want 8", hits); end
        read_pixel(18, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h43) begin err_cnt++; $display("FAIL bs_keep_C: got %h want 43", tc.ascii_out); end
        send_byte(8'h0D);
        cursor_hits(0, 16, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL cr_cursor: got %0d want 8", hits); end
        send_byte(8'h01);
        cursor_hits(0, 16, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL ctrl_ignored_cursor: got %0d want 8", hits); end
        read_pixel(0, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL ctrl_ignored_cell: got %h want 20", tc.ascii_out); end
    endtask

    task automatic test_scroll();
        int n, hits;
        logic [7:0] exp_l0 [4];
        exp_l0 = '{8'h45, 8'h46, 8'h47, 8'h48};
        hard_reset(n);
        vec_cnt++; if (n !== 12) begin err_cnt++; $display("FAIL scroll_clear_cycles: got %0d want 12", n); end
        send_str("ABCDEFGHIJK");
        cursor_hits(27, 32, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL fill_cursor: got %0d want 8", hits); end
        send_byte(8'h0A);
        n = 0;
        while (tc.in_ready !== 1'b1 && n < 50) begin
            n++;
            @(posedge clock); #1;
        end
        vec_cnt++; if (n !== 4) begin err_cnt++; $display("FAIL scroll_busy: got %0d want 4", n); end
        for (int x = 0; x < COLS; x++) begin
            read_pixel(x * FONT_W, 0);
            vec_cnt++;
            if (tc.ascii_out !== exp_l0[x]) begin
                err_cnt++; $display("FAIL scroll_line0[%0d]: got %h want %h", x, tc.ascii_out, exp_l0[x]);
            end
        end
        read_pixel(0, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h49) begin err_cnt++; $display("FAIL scroll_line1_I: got %h want 49", tc.ascii_out); end
        read_pixel(18, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h4B) begin err_cnt++; $display("FAIL scroll_line1_K: got %h want 4b", tc.ascii_out); end
        read_pixel(27, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL scroll_line1_blank: got %h want 20", tc.ascii_out); end
        for (int x = 0; x < COLS; x++) begin
            read_pixel(x * FONT_W, 32);
            vec_cnt++;
            if (tc.ascii_out !== 8'h20) begin
                err_cnt++; $display("FAIL scroll_bottom[%0d]: got %h want 20", x, tc.ascii_out);
            end
        end
        cursor_hits(0, 32, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL scroll_cursor: got %0d want 8", hits); end
        send_byte(8'h5A);
        read_pixel(0, 32);
        vec_cnt++; if (tc.ascii_out !== 8'h5A) begin err_cnt++; $display("FAIL scroll_write_Z: got %h want 5a", tc.ascii_out); end
    endtask

    task automatic test_oob_rw();
        int hits;
        send_byte(8'h08);
        read_pixel(40, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h00) begin err_cnt++; $display("FAIL oob_x_ascii: got %h want 00", tc.ascii_out); end
        vec_cnt++; if (tc.col !== 4'd4) begin err_cnt++; $display("FAIL oob_x_col: got %0d want 4", tc.col); end
        read_pixel(0, 50);
        vec_cnt++; if (tc.ascii_out !== 8'h00) begin err_cnt++; $display("FAIL oob_y_ascii: got %h want 00", tc.ascii_out); end
        vec_cnt++; if (tc.row !== 4'd2) begin err_cnt++; $display("FAIL oob_y_row: got %0d want 2", tc.row); end
        cursor_hits(36, 32, hits);
        vec_cnt++; if (hits !== 0) begin err_cnt++; $display("FAIL oob_cursor: got %0d want 0", hits); end
        cursor_hits(0, 32, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL oob_ref_cursor: got %0d want 8", hits); end
        @(negedge clock);
        wait_ready();
        tc.h_addr   = 10'd0;
        tc.v_addr   = 10'd32;
        tc.in_valid = 1'b1;
        tc.in_char  = 8'h51;
        @(posedge clock); #1;
        tc.in_valid = 1'b0;
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL rw_same_cycle: got %h want 20", tc.ascii_out); end
        @(posedge clock); #1;
        vec_cnt++; if (tc.ascii_out !== 8'h51) begin err_cnt++; $display("FAIL rw_next_cycle: got %h want 51", tc.ascii_out); end
    endtask

    task automatic test_reset_in_scroll();
        int n, hits;
        send_byte(8'h0A);
        tc.h_addr = 10'd10;
        tc.v_addr = 10'd17;
        @(posedge clock); #1;
        vec_cnt++; if (tc.in_ready !== 1'b0) begin err_cnt++; $display("FAIL mid_scroll_busy: got %b want 0", tc.in_ready); end
        vec_cnt++; if (tc.col !== 4'd1 || tc.row !== 4'd1) begin err_cnt++; $display("FAIL mid_scroll_glyph: got col %0d row %0d want 1 1", tc.col, tc.row); end
        #3;
        reset = 1'b0;
        #1;
        vec_cnt++; if (tc.in_ready !== 1'b0) begin err_cnt++; $display("FAIL abort_in_ready: got %b want 0", tc.in_ready); end
        vec_cnt++; if (tc.ascii_out !== 8'h00) begin err_cnt++; $display("FAIL abort_ascii: got %h want 00", tc.ascii_out); end
        vec_cnt++; if (tc.row !== 4'd0 || tc.col !== 4'd0) begin err_cnt++; $display("FAIL abort_glyph: got row %0d col %0d want 0 0", tc.row, tc.col); end
        vec_cnt++; if (tc.cursor_on !== 1'b0) begin err_cnt++; $display("FAIL abort_cursor: got %b want 0", tc.cursor_on); end
        repeat (2) @(posedge clock);
        release_reset(n);
        vec_cnt++; if (n !== 12) begin err_cnt++; $display("FAIL abort_clear_cycles: got %0d want 12", n); end
        read_pixel(0, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL abort_cell_0_0: got %h want 20", tc.ascii_out); end
        read_pixel(0, 32);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL abort_cell_0_2: got %h want 20", tc.ascii_out); end
        read_pixel(27, 16);
        vec_cnt++; if (tc.ascii_out !== 8'h20) begin err_cnt++; $display("FAIL abort_cell_3_1: got %h want 20", tc.ascii_out); end
        cursor_hits(0, 0, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL abort_cursor_home: got %0d want 8", hits); end
        cursor_hits(0, 32, hits);
        vec_cnt++; if (hits !== 0) begin err_cnt++; $display("FAIL abort_cursor_old: got %0d want 0", hits); end
        send_byte(8'h41);
        read_pixel(0, 0);
        vec_cnt++; if (tc.ascii_out !== 8'h41) begin err_cnt++; $display("FAIL abort_write_A: got %h want 41", tc.ascii_out); end
        cursor_hits(9, 0, hits);
        vec_cnt++; if (hits !== 8) begin err_cnt++; $display("FAIL abort_cursor_next: got %0d want 8", hits); end
    endtask

    initial begin
        reset       = 1'b0;
        tc.in_valid = 1'b0;
        tc.in_char  = 8'h00;
        tc.h_addr   = 10'd0;
        tc.v_addr   = 10'd0;
        test_reset();
        test_chars();
        test_wrap_bs();
        test_scroll();
        test_oob_rw();
        test_reset_in_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
